// File: rtl/aclk_time_counter.sv
// aclk_time_counter
// Current-time register for the alarm clock. Holds the time of day as four
// BCD digits (24-hour format, HH:MM). It advances one minute per one_minute
// strobe and accepts a validated parallel load from the keypad/set path.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   one_minute   advance strobe; may be high on consecutive cycles
//   load_new_c   single-cycle request to load new_*
//   new_ms_hr    BCD tens-of-hours to load
//   new_ls_hr    BCD units-of-hours to load
//   new_ms_min   BCD tens-of-minutes to load
//   new_ls_min   BCD units-of-minutes to load
//   ms_hr        current tens-of-hours (registered)
//   ls_hr        current units-of-hours (registered)
//   ms_min       current tens-of-minutes (registered)
//   ls_min       current units-of-minutes (registered)
//   day_tick     one-cycle pulse on the 23:59 -> 00:00 rollover
//   load_err     one-cycle pulse when a load request is rejected
module aclk_time_counter #(
  parameter logic [7:0] RESET_HOURS   = 8'h00,
  parameter logic [7:0] RESET_MINUTES = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic       day_tick,
  output logic       load_err
);

  logic [3:0] r_msHr;
  logic [3:0] r_lsHr;
  logic [3:0] r_msMin;
  logic [3:0] r_lsMin;
  logic       r_dayTick;
  logic       r_loadErr;

  logic [3:0] w_incMsHr;
  logic [3:0] w_incLsHr;
  logic [3:0] w_incMsMin;
  logic [3:0] w_incLsMin;
  logic       w_dayWrap;
  logic       w_loadLegal;

  // Next time of day after one BCD minute increment. The carry ripples
  // ls_min -> ms_min -> hours. Hours wrap to 00 only from 23, which also
  // flags the day rollover.
  always_comb begin
    w_incMsHr  = r_msHr;
    w_incLsHr  = r_lsHr;
    w_incMsMin = r_msMin;
    w_incLsMin = r_lsMin + 4'd1;
    w_dayWrap  = 1'b0;
    if (r_lsMin == 4'd9) begin
      w_incLsMin = 4'd0;
      if (r_msMin == 4'd5) begin
        w_incMsMin = 4'd0;
        if ((r_msHr == 4'd2) && (r_lsHr == 4'd3)) begin
          w_incMsHr = 4'd0;
          w_incLsHr = 4'd0;
          w_dayWrap = 1'b1;
        end else if (r_lsHr == 4'd9) begin
          w_incLsHr = 4'd0;
          w_incMsHr = r_msHr + 4'd1;
        end else begin
          w_incLsHr = r_lsHr + 4'd1;
        end
      end else begin
        w_incMsMin = r_msMin + 4'd1;
      end
    end
  end

  // A load is accepted only if every digit is a legal BCD digit and the hour
  // lies in 00-23. This keeps the counter inside the legal set.
  assign w_loadLegal = (new_ms_hr <= 4'd2) &&
                       (new_ls_hr <= 4'd9) &&
                       !((new_ms_hr == 4'd2) && (new_ls_hr > 4'd3)) &&
                       (new_ms_min <= 4'd5) &&
                       (new_ls_min <= 4'd9);

  // Time register. A load takes priority over the strobe, and a strobe that
  // coincides with a load is dropped. The pulse outputs default low on every
  // edge, so each pulse lasts a single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msHr    <= RESET_HOURS[7:4];
      r_lsHr    <= RESET_HOURS[3:0];
      r_msMin   <= RESET_MINUTES[7:4];
      r_lsMin   <= RESET_MINUTES[3:0];
      r_dayTick <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_dayTick <= 1'b0;
      r_loadErr <= 1'b0;
      if (load_new_c) begin
        if (w_loadLegal) begin
          r_msHr  <= new_ms_hr;
          r_lsHr  <= new_ls_hr;
          r_msMin <= new_ms_min;
          r_lsMin <= new_ls_min;
        end else begin
          r_loadErr <= 1'b1;
        end
      end else if (one_minute) begin
        r_msHr    <= w_incMsHr;
        r_lsHr    <= w_incLsHr;
        r_msMin   <= w_incMsMin;
        r_lsMin   <= w_incLsMin;
        r_dayTick <= w_dayWrap;
      end
    end
  end

  assign ms_hr    = r_msHr;
  assign ls_hr    = r_lsHr;
  assign ms_min   = r_msMin;
  assign ls_min   = r_lsMin;
  assign day_tick = r_dayTick;
  assign load_err = r_loadErr;

endmodule

// File: tb/tb_aclk_time_counter.sv
// tb_aclk_time_counter
// Self-checking bench for aclk_time_counter. It applies a table of directed
// one-cycle vectors, each with a hand-computed expected time and pulses.
// After the table it runs a fast-watch burst across midnight and an
// asynchronous reset asserted mid-burst.
module tb_aclk_time_counter;

  logic       clk;
  logic       reset;
  logic       oneMinute;
  logic       loadNewC;
  logic [3:0] newMsHr;
  logic [3:0] newLsHr;
  logic [3:0] newMsMin;
  logic [3:0] newLsMin;
  logic [3:0] msHr;
  logic [3:0] lsHr;
  logic [3:0] msMin;
  logic [3:0] lsMin;
  logic       dayTick;
  logic       loadErr;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        oneMin;
    logic        load;
    logic [15:0] newTime;
    logic [15:0] expTime;
    logic        expDay;
    logic        expErr;
  } vec_t;

  localparam int NumVecs = 25;
  vec_t vecs[NumVecs];

  aclk_time_counter dut (
    .clk        (clk),
    .reset      (reset),
    .one_minute (oneMinute),
    .load_new_c (loadNewC),
    .new_ms_hr  (newMsHr),
    .new_ls_hr  (newLsHr),
    .new_ms_min (newMsMin),
    .new_ls_min (newLsMin),
    .ms_hr      (msHr),
    .ls_hr      (lsHr),
    .ms_min     (msMin),
    .ls_min     (lsMin),
    .day_tick   (dayTick),
    .load_err   (loadErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic om, input logic ld,
                                 input logic [15:0] nt, input logic [15:0] et,
                                 input logic ed, input logic ee);
    vec_t v;
    v.oneMin  = om;
    v.load    = ld;
    v.newTime = nt;
    v.expTime = et;
    v.expDay  = ed;
    v.expErr  = ee;
    return v;
  endfunction

  // Drive one cycle of stimulus just after an edge, let the next rising
  // edge capture it, then return the inputs to idle.
  task automatic applyStimulus(input logic om, input logic ld, input logic [15:0] nt);
    oneMinute = om;
    loadNewC  = ld;
    {newMsHr, newLsHr, newMsMin, newLsMin} = nt;
    @(posedge clk);
    #1;
    oneMinute = 1'b0;
    loadNewC  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expTime,
                             input logic expDay, input logic expErr);
    logic [15:0] actTime;
    actTime = {msHr, lsHr, msMin, lsMin};
    testsRun++;
    if (actTime !== expTime) begin
      testsFailed++;
      $display("[TB] FAIL %s time: got %h expected %h", name, actTime, expTime);
    end
    testsRun++;
    if (dayTick !== expDay) begin
      testsFailed++;
      $display("[TB] FAIL %s day_tick: got %b expected %b", name, dayTick, expDay);
    end
    testsRun++;
    if (loadErr !== expErr) begin
      testsFailed++;
      $display("[TB] FAIL %s load_err: got %b expected %b", name, loadErr, expErr);
    end
  endtask

  initial begin
    logic [15:0] expT;
    logic [3:0]  tens;
    logic [3:0]  units;

    testsRun    = 0;
    testsFailed = 0;
    oneMinute   = 1'b0;
    loadNewC    = 1'b0;
    {newMsHr, newLsHr, newMsMin, newLsMin} = 16'h0000;

    //                om    ld    newTime   expTime   day   err
    vecs[0]  = mkVec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); // idle after reset
    vecs[1]  = mkVec(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0); // data without load ignored
    vecs[2]  = mkVec(1'b0, 1'b1, 16'h0959, 16'h0959, 1'b0, 1'b0);
    vecs[3]  = mkVec(1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0); // 09:59 -> 10:00
    vecs[4]  = mkVec(1'b0, 1'b1, 16'h1959, 16'h1959, 1'b0, 1'b0);
    vecs[5]  = mkVec(1'b1, 1'b0, 16'h0000, 16'h2000, 1'b0, 1'b0); // 19:59 -> 20:00
    vecs[6]  = mkVec(1'b1, 1'b0, 16'h0000, 16'h2001, 1'b0, 1'b0); // plain ls_min step
    vecs[7]  = mkVec(1'b0, 1'b1, 16'h2358, 16'h2358, 1'b0, 1'b0);
    vecs[8]  = mkVec(1'b1, 1'b0, 16'h0000, 16'h2359, 1'b0, 1'b0);
    vecs[9]  = mkVec(1'b0, 1'b0, 16'h0000, 16'h2359, 1'b0, 1'b0);
    vecs[10] = mkVec(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0); // midnight rollover
    vecs[11] = mkVec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0); // day_tick one cycle
    vecs[12] = mkVec(1'b0, 1'b1, 16'h0530, 16'h0530, 1'b0, 1'b0);
    vecs[13] = mkVec(1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0); // strobe dropped
    vecs[14] = mkVec(1'b1, 1'b0, 16'h0000, 16'h1235, 1'b0, 1'b0);
    vecs[15] = mkVec(1'b0, 1'b1, 16'h0707, 16'h0707, 1'b0, 1'b0);
    vecs[16] = mkVec(1'b0, 1'b1, 16'h2400, 16'h0707, 1'b0, 1'b1);
    vecs[17] = mkVec(1'b0, 1'b0, 16'h0000, 16'h0707, 1'b0, 1'b0); // load_err one cycle
    vecs[18] = mkVec(1'b0, 1'b1, 16'h1960, 16'h0707, 1'b0, 1'b1);
    vecs[19] = mkVec(1'b0, 1'b1, 16'h2A00, 16'h0707, 1'b0, 1'b1);
    vecs[20] = mkVec(1'b0, 1'b1, 16'h235F, 16'h0707, 1'b0, 1'b1);
    vecs[21] = mkVec(1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0);
    vecs[22] = mkVec(1'b1, 1'b1, 16'h2400, 16'h2359, 1'b0, 1'b1); // illegal load + strobe
    vecs[23] = mkVec(1'b1, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0); // no day_tick on load
    vecs[24] = mkVec(1'b0, 1'b0, 16'h0000, 16'h2359, 1'b0, 1'b0);

    // Reset held for three cycles; outputs must be at reset values throughout.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i].oneMin, vecs[i].load, vecs[i].newTime);
      checkOutput($sformatf("vec%0d", i), vecs[i].expTime, vecs[i].expDay, vecs[i].expErr);
    end

    // Fast-watch burst: 60 consecutive strobes from 23:00 end at 00:00, and
    // day_tick rises only on the 60th edge.
    applyStimulus(1'b0, 1'b1, 16'h2300);
    checkOutput("burst_load", 16'h2300, 1'b0, 1'b0);
    oneMinute = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 60) begin
        expT = 16'h0000;
      end else begin
        tens  = 4'(k / 10);
        units = 4'(k % 10);
        expT  = {8'h23, tens, units};
      end
      checkOutput($sformatf("burst%0d", k), expT, (k == 60), 1'b0);
    end
    oneMinute = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("burst_idle", 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset mid-burst: outputs return to reset values before
    // the next clock edge.
    applyStimulus(1'b0, 1'b1, 16'h2300);
    oneMinute = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("burst_pre_reset", 16'h2320, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    oneMinute = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset", 16'h0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/aclk_time_counter.md
Name: aclk_time_counter

Overview:
Current-time register for the alarm clock. Holds time of day as four BCD digits in 24-hour format and advances by one minute on each one-minute strobe from the time generator. Sits directly downstream of the time generator. Accepts a validated parallel load of a new time from the keypad/set path. Its registered digit outputs feed the display driver and the alarm comparator.

Parameters:
RESET_HOURS, 8'h00, BCD hours {ms,ls} loaded on reset; must be a legal value 00-23.
RESET_MINUTES, 8'h00, BCD minutes {ms,ls} loaded on reset; must be a legal value 00-59.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
one_minute  input  1  single-cycle advance strobe from time generator; may be high on consecutive cycles in fast-watch mode
load_new_c  input  1  single-cycle request to load new_time_*
new_ms_hr  input  4  BCD tens-of-hours to load
new_ls_hr  input  4  BCD units-of-hours to load
new_ms_min  input  4  BCD tens-of-minutes to load
new_ls_min  input  4  BCD units-of-minutes to load
ms_hr  output  4  current tens-of-hours, registered
ls_hr  output  4  current units-of-hours, registered
ms_min  output  4  current tens-of-minutes, registered
ls_min  output  4  current units-of-minutes, registered
day_tick  output  1  one-cycle pulse on the 23:59->00:00 rollover
load_err  output  1  one-cycle pulse when a load request is rejected

Behaviour:
- Reset (async, active-high):
  - digits = RESET_HOURS/RESET_MINUTES.
  - day_tick=0, load_err=0.
  - Reset mid-operation discards any in-progress load or strobe.
- All outputs are registered and change only on the rising edge of clk.
- day_tick and load_err are low on every cycle that does not explicitly raise them.
- Priority per edge: reset > load_new_c > one_minute > hold.
- Load (load_new_c=1 on an edge):
  - Legal when all of the following hold: new_ms_hr<=2; new_ls_hr<=9; if new_ms_hr==2 then new_ls_hr<=3; new_ms_min<=5; new_ls_min<=9.
  - Legal: digits take the new values; visible the cycle after the edge; load_err=0.
  - Illegal: digits hold their values; load_err=1 for one cycle.
  - A one_minute on the same edge is dropped in both cases; no catch-up occurs.
  - day_tick=0 on any load edge.
- Advance (one_minute=1, load_new_c=0): BCD minute increment, latency 1 edge.
  - ls_min<9: ls_min+1.
  - ls_min==9: ls_min=0 and ms_min increments.
  - ms_min==5 and ls_min==9: minutes=00 and the hour increments.
  - Hour increment: ls_hr<9 and not (ms_hr==2 and ls_hr==3) gives ls_hr+1; ls_hr==9 gives ls_hr=0, ms_hr+1.
  - 23:59 -> 00:00 with day_tick=1 on the same edge.
- Back-to-back one_minute on consecutive cycles advances one minute per cycle, with no skipped or duplicated counts.
- Digits never leave the legal set. Digit arithmetic is 4-bit BCD, with no binary carry past 9.
- Idle (no strobe, no load): all digits hold.

Test Plan:
- Reset with defaults: assert reset for 3 cycles, then release -> digits 0,0,0,0; day_tick=0, load_err=0; no change while one_minute stays low.
- Carry chain: load 09:59; pulse one_minute once -> next cycle 10:00, day_tick=0. Load 19:59 plus one pulse -> 20:00.
- Day rollover: load 23:58; pulse one_minute twice, one cycle apart.
  - After the first pulse: 23:59, day_tick=0.
  - After the second pulse: 00:00, with day_tick=1 for exactly one cycle.
- Load/strobe collision: from 05:30, raise load_new_c with 12:34 and one_minute on the same edge -> 12:34, not 12:35. The next one_minute -> 12:35.
- Illegal loads: from 07:07, request each of 24:00, 19:60, 2A:00 and 23:5F in turn.
  - Each request -> digits stay 07:07 and load_err=1 for one cycle.
  - A following legal 23:59 load -> accepted, load_err=0.
- Fast-watch burst: load 23:00; hold one_minute high for 60 consecutive cycles -> ends at 00:00, with day_tick high only on the 60th edge. Assert reset asynchronously mid-burst -> outputs return to reset values immediately.
